// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Encodings are fixed; the unused code 2'd3 is treated as illegal and recovers to idle.
package seq_divider_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Iteration counter must hold WIDTH-1 and never shrink to zero bits.
   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_cla_sub.sv
// Carry-lookahead subtractor a - b computed as a + ~b + 1.
// no_borrow_o is the carry out: high when a >= b.
module cla_sub #(
   parameter int N = 5
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         no_borrow_o
);
   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N:0]   carry;

   assign gen  = a_i & ~b_i;
   assign prop = a_i ^ ~b_i;

   // Each carry is the flattened lookahead sum over all lower bits with cin=1.
   always_comb begin : lookahead
      logic term;
      logic acc;
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < N; i++) begin
         acc  = 1'b0;
         term = 1'b1;
         for (int j = i; j >= 0; j--) begin
            acc  = acc | (gen[j] & term);
            term = term & prop[j];
         end
         carry[i+1] = acc | term;
      end
   end

   assign diff_o      = prop ^ carry[N-1:0];
   assign no_borrow_o = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock via a CLA subtractor.
//   state   | meaning
//   IDLE    | waiting for start; results held
//   RUN     | one trial subtraction per cycle, busy=1
//   DONE    | done=1 for one cycle; start accepted as in IDLE
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   seq_divider_if.slave bus
);
   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   sub_diff;
   logic             no_borrow;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic             unused_msb;
   logic             accept;

   assign shifted = {rem_q, quo_q[WIDTH-1]};

   cla_sub #(
      .N (WIDTH + 1)
   ) u_sub (
      .a_i         (shifted),
      .b_i         ({1'b0, dvs_q}),
      .diff_o      (sub_diff),
      .no_borrow_o (no_borrow)
   );

   // Partial remainder stays below the divisor, so the top bit is always dropped.
   assign rem_next   = no_borrow ? sub_diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_next   = {quo_q[WIDTH-2:0], no_borrow};
   assign unused_msb = sub_diff[WIDTH] ^ shifted[WIDTH];

   assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept && (bus.divisor != '0)) begin
               dvs_d   = bus.divisor;
               rem_d   = '0;
               quo_d   = bus.dividend;
               cnt_d   = CW'(WIDTH - 1);
               state_d = ST_RUN;
            end else if (accept) begin
               quotient_d  = '1;
               remainder_d = bus.dividend;
               dbz_d       = 1'b1;
               state_d     = ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            rem_d = rem_next;
            quo_d = quo_next;
            if (cnt_q == '0) begin
               quotient_d  = quo_next;
               remainder_d = rem_next;
               dbz_d       = 1'b0;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign bus.busy        = (state_q == ST_RUN);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle model built on / and %, per-cycle compare, directed literal checks.
module tb_seq_divider;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(W)) bus ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: an accepted op either finishes W+1 edges later with a/b, a%b,
   // or, for divisor 0, finishes on the accepting edge with all-ones and the dividend.
   bit m_valid = 1'b0;
   bit m_busy, m_done, m_dbz;
   int m_left, m_q, m_r, p_q, p_r;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1'b1;
         m_busy = 0; m_done = 0; m_dbz = 0;
         m_left = 0; m_q = 0; m_r = 0;
      end else if (m_valid) begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 0;
            end
         end else if (bus.start) begin
            if (bus.divisor == 0) begin
               m_done = 1; m_q = (1 << W) - 1; m_r = int'(bus.dividend); m_dbz = 1;
            end else begin
               m_busy = 1; m_left = W;
               p_q = int'(bus.dividend) / int'(bus.divisor);
               p_r = int'(bus.dividend) % int'(bus.divisor);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("busy", 32'(bus.busy), 32'(m_busy));
         check("done", 32'(bus.done), 32'(m_done));
         check("quotient", 32'(bus.quotient), 32'(m_q));
         check("remainder", 32'(bus.remainder), 32'(m_r));
         check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
         check("busy_and_done", 32'(bus.busy & bus.done), 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_op(input int a, input int b);
      bus.start    = 1'b1;
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, input int exp_lat, input int exp_q,
                            input int exp_r, input int exp_dbz, input string tag);
      int lat = lat0;
      while (!bus.done && lat < 20) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({tag, " done_seen"}, 32'(bus.done), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " q"}, 32'(bus.quotient), 32'(exp_q));
      check({tag, " r"}, 32'(bus.remainder), 32'(exp_r));
      check({tag, " dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
      check({tag, " model_q"}, 32'(m_q), 32'(exp_q));
      check({tag, " model_r"}, 32'(m_r), 32'(exp_r));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " busy"}, 32'(bus.busy), 32'd0);
      check({tag, " done"}, 32'(bus.done), 32'd0);
      check({tag, " q"}, 32'(bus.quotient), 32'd0);
      check({tag, " r"}, 32'(bus.remainder), 32'd0);
      check({tag, " dbz"}, 32'(bus.div_by_zero), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_zero("reset");

      start_op(13, 3);  wait_done(1, 5, 4, 1, 0, "13/3");
      @(negedge clk);
      start_op(15, 1);  wait_done(1, 5, 15, 0, 0, "15/1");
      @(negedge clk);
      start_op(6, 9);   wait_done(1, 5, 0, 6, 0, "6/9");
      @(negedge clk);
      start_op(15, 15); wait_done(1, 5, 1, 0, 0, "15/15");
      @(negedge clk);
      start_op(9, 0);   wait_done(1, 1, 15, 9, 1, "9/0");
      @(negedge clk);

      // Second start with new operands while running must be ignored.
      start_op(13, 3);
      bus.start = 1'b1; bus.dividend = 4'd8; bus.divisor = 4'd2;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(2, 5, 4, 1, 0, "ignored_start");

      // Start issued in the done cycle is accepted.
      start_op(8, 2);   wait_done(1, 5, 4, 0, 0, "back_to_back");
      @(negedge clk);

      start_op(14, 5);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_zero("mid_reset");
      rst_n = 1'b1;
      start_op(14, 5);  wait_done(1, 5, 2, 4, 0, "14/5_after_reset");
      @(negedge clk);

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            start_op(a, b);
            if (b == 0) wait_done(1, 1, 15, a, 1, "exh");
            else        wait_done(1, 5, a / b, a % b, 0, "exh");
            if (((a + b) % 3) == 0) @(negedge clk);
         end
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
